// File: rtl/elevator_pkg.sv
// Shared types and helpers for the single-car elevator controller.
package elevator_pkg;

  localparam int unsigned MaxFloors = 16;
  localparam int unsigned MaxFloorW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDn,
    StDoorOpen
  } state_e;

  // 1 when any pending call lies strictly above (up=1) or below (up=0) the car.
  function automatic logic ahead_mask(input logic [MaxFloors-1:0] pending,
                                      input logic [MaxFloorW-1:0] cur,
                                      input logic                 up);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < MaxFloors; k++) begin
      if (pending[k] && (up ? (k > 32'(cur)) : (k < 32'(cur)))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Phase timer: counts 0..last_i while enabled, flags the terminal count and
// restarts from 0 on the following cycle.
module dwell_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] last_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == last_i);

  always_comb begin
    count_d = count_q + Width'(1);
    if (load_i || !en_i || tc_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches calls, serves them in SCAN order and
// times per-floor travel and door dwell.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS    = 4,
  parameter int unsigned MOVE_CYCLES = 50,
  parameter int unsigned DOOR_CYCLES = 100,
  localparam int unsigned FLOOR_W    = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] req_i,
  output logic [FLOOR_W-1:0]  cur_floor_o,
  output logic                moving_o,
  output logic                dir_up_o,
  output logic                door_open_o,
  output logic [N_FLOORS-1:0] pending_o
);

  localparam int unsigned TimerMax = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] MoveLast = TimerW'(MOVE_CYCLES - 1);
  localparam logic [TimerW-1:0] DoorLast = TimerW'(DOOR_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
  logic                 dir_up_q, dir_up_d;
  logic [N_FLOORS-1:0]  pending_q, pending_d;

  logic                 ahead_up, ahead_dn;
  logic                 timer_en, timer_load, timer_tc;
  logic [TimerW-1:0]    timer_last;

  assign ahead_up = ahead_mask(MaxFloors'(pending_q), MaxFloorW'(cur_floor_q), 1'b1);
  assign ahead_dn = ahead_mask(MaxFloors'(pending_q), MaxFloorW'(cur_floor_q), 1'b0);

  assign timer_en   = (state_q != StIdle);
  assign timer_last = (state_q == StDoorOpen) ? DoorLast : MoveLast;
  // Any phase change restarts the dwell count from zero.
  assign timer_load = (state_d != state_q);

  dwell_timer #(
    .Width (TimerW)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (timer_en),
    .load_i (timer_load),
    .last_i (timer_last),
    .tc_o   (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    pending_d   = pending_q | req_i;
    // A call at the floor whose door is open is absorbed rather than latched.
    if (state_q == StDoorOpen) begin
      pending_d[cur_floor_q] = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q[cur_floor_q]) begin
          state_d = StDoorOpen;
        end else if (ahead_up) begin
          state_d  = StMoveUp;
          dir_up_d = 1'b1;
        end else if (ahead_dn) begin
          state_d  = StMoveDn;
          dir_up_d = 1'b0;
        end
      end
      StMoveUp, StMoveDn: begin
        if (timer_tc) begin
          cur_floor_d = (state_q == StMoveUp) ? cur_floor_q + FLOOR_W'(1)
                                              : cur_floor_q - FLOOR_W'(1);
          if (pending_q[cur_floor_d]) begin
            state_d = StDoorOpen;
          end
        end
      end
      StDoorOpen: begin
        if (timer_tc) begin
          if (dir_up_q ? ahead_up : ahead_dn) begin
            state_d = dir_up_q ? StMoveUp : StMoveDn;
          end else if (dir_up_q ? ahead_dn : ahead_up) begin
            state_d  = dir_up_q ? StMoveDn : StMoveUp;
            dir_up_d = !dir_up_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
    end
  end

  assign cur_floor_o = cur_floor_q;
  assign dir_up_o    = dir_up_q;
  assign pending_o   = pending_q;
  assign moving_o    = (state_q == StMoveUp) || (state_q == StMoveDn);
  assign door_open_o = (state_q == StDoorOpen);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed and randomized bench for elevator_ctrl against a cycle-level
// behavioural model of the SCAN service rules.
module tb_elevator_ctrl;

  localparam int NF = 4;
  localparam int MC = 4;
  localparam int DC = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic [1:0] cur_floor_o;
  logic       moving_o;
  logic       dir_up_o;
  logic       door_open_o;
  logic [3:0] pending_o;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 moving up, 2 moving down, 3 door open.
  int         m_mode;
  int         m_t;
  int         m_floor;
  logic       m_dir;
  logic [3:0] m_pend;

  int   door_cnt;
  int   move_cnt;
  logic door_prev;
  int   door_floors[$];
  bit   reached;

  elevator_ctrl #(
    .N_FLOORS    (NF),
    .MOVE_CYCLES (MC),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .cur_floor_o (cur_floor_o),
    .moving_o    (moving_o),
    .dir_up_o    (dir_up_o),
    .door_open_o (door_open_o),
    .pending_o   (pending_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_t     = 0;
    m_floor = 0;
    m_dir   = 1'b1;
    m_pend  = '0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] np;
    bit above, below;
    above = 0;
    below = 0;
    for (int k = 0; k < NF; k++) begin
      if (m_pend[k] && k > m_floor) above = 1;
      if (m_pend[k] && k < m_floor) below = 1;
    end
    np = m_pend | r;
    if (m_mode == 3) np[m_floor] = 1'b0;
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          m_mode = 3;
          m_t    = 0;
        end else if (above) begin
          m_mode = 1;
          m_dir  = 1'b1;
        end else if (below) begin
          m_mode = 2;
          m_dir  = 1'b0;
        end
      end
      1, 2: begin
        if (m_t == MC - 1) begin
          m_floor = m_floor + ((m_mode == 1) ? 1 : -1);
          m_t     = 0;
          if (m_pend[m_floor]) m_mode = 3;
        end else begin
          m_t++;
        end
      end
      default: begin
        if (m_t == DC - 1) begin
          m_t = 0;
          if (m_dir ? above : below) begin
            m_mode = m_dir ? 1 : 2;
          end else if (m_dir ? below : above) begin
            m_dir  = !m_dir;
            m_mode = m_dir ? 1 : 2;
          end else begin
            m_mode = 0;
          end
        end else begin
          m_t++;
        end
      end
    endcase
    m_pend = np;
  endtask

  task automatic compare_all();
    chk("floor", 32'(cur_floor_o), 32'(m_floor));
    chk("moving", 32'(moving_o), 32'(m_mode == 1 || m_mode == 2));
    chk("dir_up", 32'(dir_up_o), 32'(m_dir));
    chk("door", 32'(door_open_o), 32'(m_mode == 3));
    chk("pending", 32'(pending_o), 32'(m_pend));
    chk("excl", 32'(moving_o && door_open_o), 32'(0));
    chk("bound", 32'(moving_o && ((dir_up_o && cur_floor_o == 2'd3) ||
                                  (!dir_up_o && cur_floor_o == 2'd0))), 32'(0));
  endtask

  task automatic tick(input logic [3:0] r);
    req_i = r;
    model_step(r);
    @(posedge clk);
    #1;
    compare_all();
    if (door_open_o) door_cnt++;
    if (moving_o) move_cnt++;
    if (door_open_o && !door_prev) door_floors.push_back(int'(cur_floor_o));
    door_prev = door_open_o;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (m_mode == 0 && m_pend == 4'd0) break;
      tick(4'd0);
    end
    chk("idle_reached", 32'({moving_o, door_open_o, |pending_o}), 32'(0));
  endtask

  function automatic int qat(input int idx);
    return (door_floors.size() > idx) ? door_floors[idx] : 99;
  endfunction

  initial begin
    req_i     = '0;
    rst_n     = 1'b1;
    door_prev = 1'b0;
    door_cnt  = 0;
    move_cnt  = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    compare_all();
    #10 rst_n = 1'b1;

    // Call at the idle floor: door for exactly DC cycles, call absorbed.
    door_cnt = 0;
    tick(4'b0001);
    repeat (8) tick(4'd0);
    chk("t2_door_cycles", 32'(door_cnt), 32'(DC));
    chk("t2_pending", 32'(pending_o), 32'(0));

    // Ground to top: three floors of travel, door at 3, then idle.
    door_cnt = 0;
    move_cnt = 0;
    tick(4'b1000);
    repeat (24) tick(4'd0);
    chk("t3_move_cycles", 32'(move_cnt), 32'(3 * MC));
    chk("t3_door_cycles", 32'(door_cnt), 32'(DC));
    chk("t3_floor", 32'(cur_floor_o), 32'(3));

    // Back to 0, then 0100 with 0010 arriving while leaving floor 0.
    tick(4'b0001);
    wait_idle();
    door_floors.delete();
    tick(4'b0100);
    tick(4'd0);
    tick(4'b0010);
    wait_idle();
    chk("t4_stops", 32'(door_floors.size()), 32'(2));
    chk("t4_first", 32'(qat(0)), 32'(1));
    chk("t4_second", 32'(qat(1)), 32'(2));

    // From 1 heading to 3, a call at 0 is deferred until after reversal.
    tick(4'b0010);
    wait_idle();
    door_floors.delete();
    tick(4'b1000);
    tick(4'd0);
    tick(4'd0);
    tick(4'b0001);
    wait_idle();
    chk("t5_stops", 32'(door_floors.size()), 32'(2));
    chk("t5_first", 32'(qat(0)), 32'(3));
    chk("t5_second", 32'(qat(1)), 32'(0));
    chk("t5_dir", 32'(dir_up_o), 32'(0));

    // Call held at the open floor: door still closes after DC cycles.
    door_cnt = 0;
    repeat (5) tick(4'b0001);
    repeat (3) tick(4'd0);
    chk("t6_door_cycles", 32'(door_cnt), 32'(DC));
    chk("t6_pending", 32'(pending_o), 32'(0));

    // Simultaneous top and ground calls from floor 1: up wins.
    tick(4'b0010);
    wait_idle();
    door_floors.delete();
    tick(4'b1001);
    wait_idle();
    chk("t6_tie_stops", 32'(door_floors.size()), 32'(2));
    chk("t6_tie_first", 32'(qat(0)), 32'(3));
    chk("t6_tie_second", 32'(qat(1)), 32'(0));

    // Sparse random calls checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) tick(4'($urandom_range(0, 15)));
      else tick(4'd0);
    end
    wait_idle();

    // Asynchronous reset while moving up past floor 2.
    tick(4'b0001);
    wait_idle();
    tick(4'b1000);
    reached = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_floor == 2 && m_mode == 1) begin
        reached = 1;
        break;
      end
      tick(4'd0);
    end
    chk("t1_reach_floor2", 32'(reached), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    door_prev = 1'b0;
    compare_all();
    #3 rst_n = 1'b1;
    repeat (4) tick(4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
